// File: rtl/reg_file_loader_if.sv
// Bundle of the loader's byte stream, core-side register-file request and
// reg_file-side write port, plus the load status flags.
interface reg_file_loader_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         Start;
  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;
  logic [1:0]   CoreRegWrite;
  logic [D-1:0] CoreReadReg1;
  logic [D-1:0] CoreReadReg2;
  logic [W-1:0] CoreWriteValue;
  logic [1:0]   RegWrite;
  logic [D-1:0] ReadReg1;
  logic [D-1:0] ReadReg2;
  logic [W-1:0] WriteValue;
  logic         Busy;
  logic         Done;

  // Loader side
  modport slave (
    input  Start, InValid, InData,
    input  CoreRegWrite, CoreReadReg1, CoreReadReg2, CoreWriteValue,
    output InReady, RegWrite, ReadReg1, ReadReg2, WriteValue, Busy, Done
  );

  // Driver side (core + byte source + reg_file observer)
  modport master (
    output Start, InValid, InData,
    output CoreRegWrite, CoreReadReg1, CoreReadReg2, CoreWriteValue,
    input  InReady, RegWrite, ReadReg1, ReadReg2, WriteValue, Busy, Done
  );
endinterface

// File: rtl/reg_file_loader.sv
// Writer-side front end for reg_file: loads 2**D bytes from a valid/ready
// stream into registers 0..2**D-1, stalling the core while a pass runs and
// passing core requests straight through otherwise.
module reg_file_loader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  reg_file_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [D-1:0] LAST_IDX = '1;

  state_e       state_q, state_d;
  logic [D-1:0] index_q, index_d;
  logic         pend_valid_q, pend_valid_d;
  logic [D-1:0] pend_addr_q, pend_addr_d;
  logic [W-1:0] pend_data_q, pend_data_d;

  logic         in_ready;
  logic         hs;
  logic         busy;
  logic         done;
  logic [1:0]   reg_write;
  logic [D-1:0] read_reg1;
  logic [W-1:0] write_value;

  // State register and pending-write register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Next state: pass sequencing, index advance and capture of accepted byte
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_d = ST_LOAD;
          index_d = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = index_q;
          pend_data_d  = bus.InData;
          if (index_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: loader drives the write port while busy, core passes through otherwise.
  // A pending write is suppressed in a Reset cycle so an aborted pass never lands it.
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    reg_write   = bus.CoreRegWrite;
    read_reg1   = bus.CoreReadReg1;
    write_value = bus.CoreWriteValue;
    unique case (state_q)
      ST_LOAD, ST_DRAIN: begin
        in_ready    = (state_q == ST_LOAD);
        busy        = 1'b1;
        reg_write   = (pend_valid_q && !Reset) ? 2'b01 : 2'b00;
        read_reg1   = pend_addr_q;
        write_value = pend_data_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    hs = in_ready && bus.InValid;
  end

  assign bus.InReady    = in_ready;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.RegWrite   = reg_write;
  assign bus.ReadReg1   = read_reg1;
  assign bus.ReadReg2   = bus.CoreReadReg2;
  assign bus.WriteValue = write_value;

endmodule
